// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width and Gray/binary helpers
// used by both the write-side and read-side pointer handlers.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;

    typedef logic [PTR_WIDTH_DEF:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        for (int i = 0; i <= PTR_WIDTH_DEF; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterised combinational Gray-to-binary converter.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wrptr_full_ctrl.sv
// Write-side pointer and full/almost-full/overflow control for an async FIFO,
// running entirely in the wrclk domain against a synchronised Gray read pointer.
module wrptr_full_ctrl
    import fifo_pkg::PTR_WIDTH_DEF;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wrclk,
    input  logic                 wrrst,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH:0]   g_rdptr_sync,
    input  logic                 clr_ovf,
    output logic [PTR_WIDTH:0]   b_wrptr,
    output logic [PTR_WIDTH:0]   g_wrptr,
    output logic                 fifo_full,
    output logic                 fifo_almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 wr_ack,
    output logic                 overflow
);

    localparam logic [PTR_WIDTH:0] AFULL_T = (PTR_WIDTH + 1)'(AFULL_THRESH);

    logic               accept;
    logic [PTR_WIDTH:0] b_next;
    logic [PTR_WIDTH:0] g_next;
    logic [PTR_WIDTH:0] b_rdptr;
    logic [PTR_WIDTH:0] level_next;
    logic               full_next;

    gray2bin #(
        .W (PTR_WIDTH + 1)
    ) u_rd_g2b (
        .gray (g_rdptr_sync),
        .bin  (b_rdptr)
    );

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits differ and the rest match.
    always_comb begin
        accept     = wr_en & ~fifo_full;
        b_next     = b_wrptr + {{PTR_WIDTH{1'b0}}, accept};
        g_next     = (b_next >> 1) ^ b_next;
        full_next  = (g_next == {~g_rdptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                 g_rdptr_sync[PTR_WIDTH-2:0]});
        level_next = b_next - b_rdptr;
    end

    always_ff @(posedge wrclk) begin
        if (wrrst) begin
            b_wrptr          <= '0;
            g_wrptr          <= '0;
            wr_level         <= '0;
            fifo_full        <= 1'b0;
            fifo_almost_full <= 1'b0;
            wr_ack           <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            b_wrptr          <= b_next;
            g_wrptr          <= g_next;
            wr_level         <= level_next;
            fifo_full        <= full_next;
            fifo_almost_full <= (level_next >= AFULL_T);
            wr_ack           <= accept;
            // A rejected write in the same cycle as a clear keeps the flag set.
            overflow         <= (wr_en & fifo_full) | (overflow & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_wrptr_full_ctrl.sv
// Scoreboard bench for wrptr_full_ctrl (PTR_WIDTH=3, AFULL_THRESH=6) driven by
// a directed vector table with hand-computed register contents after each edge.
module tb_wrptr_full_ctrl;

    logic       wrclk = 1'b0;
    logic       wrrst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] g_rdptr_sync = 4'd0;
    logic       clr_ovf = 1'b0;
    logic [3:0] b_wrptr;
    logic [3:0] g_wrptr;
    logic       fifo_full;
    logic       fifo_almost_full;
    logic [3:0] wr_level;
    logic       wr_ack;
    logic       overflow;

    wrptr_full_ctrl #(
        .PTR_WIDTH    (3),
        .AFULL_THRESH (6)
    ) dut (
        .wrclk            (wrclk),
        .wrrst            (wrrst),
        .wr_en            (wr_en),
        .g_rdptr_sync     (g_rdptr_sync),
        .clr_ovf          (clr_ovf),
        .b_wrptr          (b_wrptr),
        .g_wrptr          (g_wrptr),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .wr_level         (wr_level),
        .wr_ack           (wr_ack),
        .overflow         (overflow)
    );

    always #5 wrclk = ~wrclk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [3:0] rd;
        logic       clr;
        logic [3:0] b;
        logic [3:0] g;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ack;
        logic       ovf;
        int         id;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic we, logic [3:0] rd, logic clr,
                                logic [3:0] b, logic [3:0] g, logic full, logic af,
                                logic [3:0] lvl, logic ack, logic ovf);
        vec_t v;
        v.rst = rst; v.we = we; v.rd = rd; v.clr = clr;
        v.b = b; v.g = g; v.full = full; v.af = af;
        v.lvl = lvl; v.ack = ack; v.ovf = ovf; v.id = 0;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0h want %0h", name, id, act, req);
        end
    endtask

    // Monitor: after each rising edge the DUT presents a fresh register set.
    initial begin
        forever begin
            @(posedge wrclk);
            #1;
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                chk("b_wrptr",   e.id, b_wrptr,                   e.b);
                chk("g_wrptr",   e.id, g_wrptr,                   e.g);
                chk("fifo_full", e.id, {3'b0, fifo_full},         {3'b0, e.full});
                chk("afull",     e.id, {3'b0, fifo_almost_full},  {3'b0, e.af});
                chk("wr_level",  e.id, wr_level,                  e.lvl);
                chk("wr_ack",    e.id, {3'b0, wr_ack},            {3'b0, e.ack});
                chk("overflow",  e.id, {3'b0, overflow},          {3'b0, e.ovf});
            end
        end
    end

    initial begin
        //           rst we  rd      clr  b       g        full af  lvl    ack ovf
        // reset held with writes requested
        vecs.push_back(mk(1, 1, 4'b0000, 0, 4'd0,  4'b0000, 0, 0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'b0000, 0, 4'd0,  4'b0000, 0, 0, 4'd0, 0, 0));
        // fill from empty with read pointer parked at 0
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd1,  4'b0001, 0, 0, 4'd1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd2,  4'b0011, 0, 0, 4'd2, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd3,  4'b0010, 0, 0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd4,  4'b0110, 0, 0, 4'd4, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd5,  4'b0111, 0, 0, 4'd5, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd6,  4'b0101, 0, 1, 4'd6, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd7,  4'b0100, 0, 1, 4'd7, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd8,  4'b1100, 1, 1, 4'd8, 1, 0));
        // write while full, then set-wins-over-clear, then clear
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd8,  4'b1100, 1, 1, 4'd8, 0, 1));
        vecs.push_back(mk(0, 1, 4'b0000, 1, 4'd8,  4'b1100, 1, 1, 4'd8, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd8,  4'b1100, 1, 1, 4'd8, 0, 0));
        // read pointer advances to 1: write in same cycle still rejected
        vecs.push_back(mk(0, 1, 4'b0001, 0, 4'd8,  4'b1100, 0, 1, 4'd7, 0, 1));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 4'd9,  4'b1101, 1, 1, 4'd8, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0001, 1, 4'd9,  4'b1101, 1, 1, 4'd8, 0, 0));
        // drain to empty, then write across the pointer wrap
        vecs.push_back(mk(0, 0, 4'b1101, 0, 4'd9,  4'b1101, 0, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1101, 0, 4'd10, 4'b1111, 0, 0, 4'd1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1101, 0, 4'd11, 4'b1110, 0, 0, 4'd2, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1101, 0, 4'd12, 4'b1010, 0, 0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1101, 0, 4'd13, 4'b1011, 0, 0, 4'd4, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 4'd14, 4'b1001, 0, 0, 4'd4, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 4'd15, 4'b1000, 0, 0, 4'd5, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 4'd0,  4'b0000, 0, 1, 4'd6, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1010, 0, 4'd1,  4'b0001, 0, 0, 4'd5, 1, 0));
        vecs.push_back(mk(0, 0, 4'b1010, 0, 4'd1,  4'b0001, 0, 0, 4'd5, 0, 0));
        // reset mid-operation, first write right after release
        vecs.push_back(mk(1, 1, 4'b0000, 0, 4'd0,  4'b0000, 0, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 4'd1,  4'b0001, 0, 0, 4'd1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            v.id = i;
            @(negedge wrclk);
            wrrst        = v.rst;
            wr_en        = v.we;
            g_rdptr_sync = v.rd;
            clr_ovf      = v.clr;
            exp_q.push_back(v);
        end
        @(negedge wrclk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(negedge wrclk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wrptr_full_ctrl.md
WRPTR_FULL_CTRL -- requirements
Module: wrptr_full_ctrl

Interface
REQ-001 Parameter PTR_WIDTH, default 3: address width; FIFO depth is 2^PTR_WIDTH; PTR_WIDTH >= 2 SHALL hold.
REQ-002 Parameter AFULL_THRESH, default 6: fill level at or above which almost-full SHALL assert; range 1..2^PTR_WIDTH.
REQ-003 wrclk  input  1  write-domain clock; the single clock; all state SHALL update on its rising edge.
REQ-004 wrrst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write request from producer.
REQ-006 g_rdptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wrclk domain.
REQ-007 clr_ovf  input  1  clears sticky overflow flag.
REQ-008 b_wrptr  output  PTR_WIDTH+1  registered binary write pointer; low PTR_WIDTH bits address the memory.
REQ-009 g_wrptr  output  PTR_WIDTH+1  registered Gray write pointer, sent to read-domain synchroniser.
REQ-010 fifo_full  output  1  registered full flag.
REQ-011 fifo_almost_full  output  1  registered almost-full flag.
REQ-012 wr_level  output  PTR_WIDTH+1  registered fill level as seen from write domain, 0..2^PTR_WIDTH.
REQ-013 wr_ack  output  1  one-cycle pulse, high in the cycle after an accepted write.
REQ-014 overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-015 accept = wr_en AND NOT fifo_full; write accepted only when accept = 1.
REQ-016 b_next = b_wrptr + accept, modulo 2^(PTR_WIDTH+1); wrap from all-ones to 0 is natural overflow.
REQ-017 g_next = (b_next >> 1) XOR b_next; b_wrptr <= b_next and g_wrptr <= g_next each cycle.
REQ-018 full_next = (g_next == {~g_rdptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rdptr_sync[PTR_WIDTH-2:0]}); fifo_full <= full_next; full SHALL assert the cycle after the accept that fills the FIFO (no write beyond depth).
REQ-019 level_next = b_next - gray2bin(g_rdptr_sync), modulo 2^(PTR_WIDTH+1); wr_level <= level_next.
REQ-020 fifo_almost_full <= (level_next >= AFULL_THRESH).
REQ-021 wr_ack <= accept.
REQ-022 overflow <= (wr_en AND fifo_full) OR (overflow AND NOT clr_ovf); simultaneous set and clear: set wins.
REQ-023 wr_en while full: pointers, wr_ack unchanged/low; only overflow affected.
REQ-024 Read pointer advancing while full: fifo_full SHALL deassert one cycle after g_rdptr_sync changes; a write in that same cycle is still rejected.
REQ-025 Flags pessimistic by design (stale g_rdptr_sync can only overstate level, never understate).

Reset
REQ-026 While wrrst = 1 at a rising edge: b_wrptr, g_wrptr, wr_level = 0; fifo_full, fifo_almost_full, wr_ack, overflow = 0.
REQ-027 Reset SHALL override wr_en and clr_ovf; reset mid-operation discards in-flight writes; first accept possible in the first cycle with wrrst = 0.

Structure
REQ-028 Shared package fifo_pkg SHALL hold default PTR_WIDTH and bin2gray/gray2bin functions, shared with the read-side pointer handler.
REQ-029 One sub-module gray2bin (combinational, width-parameterised) SHALL convert g_rdptr_sync for level computation.

Verification (PTR_WIDTH=3, AFULL_THRESH=6)
REQ-030 Reset: wrrst=1 two cycles with wr_en=1 -> all outputs 0; release -> first write gives b_wrptr=1, g_wrptr=4'b0001, wr_ack=1 next cycle.
REQ-031 Fill: g_rdptr_sync=0, wr_en=1 for 9 cycles -> after 8th accept b_wrptr=4'b1000, g_wrptr=4'b1100, wr_level=8, fifo_full=1; 9th rejected, overflow=1, wr_ack=0.
REQ-032 Almost full: after 6th accept wr_level=6 and fifo_almost_full=1; after 5th it is 0.
REQ-033 Wrap: drive g_rdptr_sync to track reads; b_wrptr 4'b1111 -> 4'b0000, g_wrptr 4'b1000 -> 4'b0000, wr_level correct across wrap, no false full.
REQ-034 Overflow clear: overflow=1, wr_en=1 while full with clr_ovf=1 -> overflow stays 1; next cycle clr_ovf=1, wr_en=0 -> overflow=0.
REQ-035 Full release: full, g_rdptr_sync advances by one -> fifo_full=0 next cycle, wr_level=7; a write then fills again.
